player_input: RTL and testbench

PLAYER_INPUT -- requirements
Module: player_input

---
 rtl/overcooked_pkg.sv | 33 +++
 rtl/rise_detect.sv | 25 ++
 rtl/player_input.sv | 162 ++++++++++++++++
 tb/tb_player_input.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/overcooked_pkg.sv
// Shared types and constants for the player input path.
// PLAYER_INPUT_REPEAT_EN selects the auto-repeat state set; without it a
// held direction produces a single move.
package overcooked_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int unsigned REPEAT_DELAY_DEFAULT = 12;
    localparam int unsigned REPEAT_RATE_DEFAULT  = 4;

`ifdef PLAYER_INPUT_REPEAT_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } state_t;
`endif

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// One-cycle pulse on a 0->1 transition of a level input.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic prev_d;

    // Remember last-cycle level; reset loads the live level so a level
    // already high during reset does not produce an edge afterwards.
    always_ff @(posedge clock) begin
        if (reset) prev_q <= level;
        else       prev_q <= prev_d;
    end

    // Edge = high now, low on the previous cycle.
    always_comb begin
        prev_d = level;
        pulse  = level & ~prev_q;
    end

endmodule

// File: rtl/player_input.sv
// Frame-synchronous player controls: direction moves with optional
// auto-repeat, chop press/hold and carry toggle events.
// Macro PLAYER_INPUT_REPEAT_EN enables auto-repeat (IDLE/DELAY/REPEAT);
// otherwise a single HELD state gives one move per press or change.
module player_input
    import overcooked_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic vsync,
    input  logic left,
    input  logic right,
    input  logic up,
    input  logic down,
    input  logic chop,
    input  logic carry,
    output logic move_valid,
    output dir_t move_dir,
    output dir_t facing,
    output logic chop_start,
    output logic chopping,
    output logic carry_req,
    output logic carry_level
);

    localparam int unsigned CNT_MAX = max_u(REPEAT_DELAY, REPEAT_RATE);
    localparam int unsigned CNT_W   = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
`ifdef PLAYER_INPUT_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_THR = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_THR  = CNT_W'(REPEAT_RATE);
`endif

    logic             frame_tick;
    logic             any_dir;
    dir_t             active_dir;
    logic [CNT_W-1:0] cnt_inc;
    logic             do_move;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             move_valid_q, move_valid_d;
    dir_t             move_dir_q, move_dir_d;
    dir_t             facing_q, facing_d;
    logic             chop_start_q, chop_start_d;
    logic             chopping_q, chopping_d;
    logic             chop_prev_q, chop_prev_d;
    logic             carry_req_q, carry_req_d;
    logic             carry_level_q, carry_level_d;

    rise_detect u_frame_tick (
        .clock (clock),
        .reset (reset),
        .level (vsync),
        .pulse (frame_tick)
    );

    // Active direction with fixed priority up > down > left > right; saturating count.
    always_comb begin
        any_dir = up | down | left | right;
        if (up)        active_dir = DIR_UP;
        else if (down) active_dir = DIR_DOWN;
        else if (left) active_dir = DIR_LEFT;
        else           active_dir = DIR_RIGHT;
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // State register plus all frame-aligned output/sample registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            move_valid_q  <= 1'b0;
            move_dir_q    <= DIR_DOWN;
            facing_q      <= DIR_DOWN;
            chop_start_q  <= 1'b0;
            chopping_q    <= 1'b0;
            chop_prev_q   <= chop;
            carry_req_q   <= 1'b0;
            carry_level_q <= carry;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            move_valid_q  <= move_valid_d;
            move_dir_q    <= move_dir_d;
            facing_q      <= facing_d;
            chop_start_q  <= chop_start_d;
            chopping_q    <= chopping_d;
            chop_prev_q   <= chop_prev_d;
            carry_req_q   <= carry_req_d;
            carry_level_q <= carry_level_d;
        end
    end

    // Next state, frame counter and move decision, evaluated only on frame_tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        do_move = 1'b0;
        if (frame_tick) begin
            if (!any_dir) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (state_q == ST_IDLE || active_dir != facing_q) begin
                do_move = 1'b1;
                cnt_d   = '0;
`ifdef PLAYER_INPUT_REPEAT_EN
                state_d = ST_DELAY;
`else
                state_d = ST_HELD;
`endif
            end else begin
                cnt_d = cnt_inc;
`ifdef PLAYER_INPUT_REPEAT_EN
                if (state_q == ST_DELAY && cnt_inc >= DELAY_THR) begin
                    do_move = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_REPEAT;
                end else if (state_q == ST_REPEAT && cnt_inc >= RATE_THR) begin
                    do_move = 1'b1;
                    cnt_d   = '0;
                end
`endif
            end
        end
    end

    // Output values for the cycle after frame_tick; pulses default low.
    always_comb begin
        move_valid_d  = 1'b0;
        chop_start_d  = 1'b0;
        carry_req_d   = 1'b0;
        move_dir_d    = move_dir_q;
        facing_d      = facing_q;
        chopping_d    = chopping_q;
        chop_prev_d   = chop_prev_q;
        carry_level_d = carry_level_q;
        if (frame_tick) begin
            if (do_move) begin
                move_valid_d = 1'b1;
                move_dir_d   = active_dir;
                facing_d     = active_dir;
            end
            chop_start_d  = chop & ~chop_prev_q;
            chopping_d    = chop;
            chop_prev_d   = chop;
            carry_req_d   = carry ^ carry_level_q;
            carry_level_d = carry;
        end
    end

    assign move_valid  = move_valid_q;
    assign move_dir    = move_dir_q;
    assign facing      = facing_q;
    assign chop_start  = chop_start_q;
    assign chopping    = chopping_q;
    assign carry_req   = carry_req_q;
    assign carry_level = carry_level_q;

endmodule

// File: tb/tb_player_input.sv
// Bench for player_input: frame vectors from a table plus hand-built
// multi-frame sequences; expected outputs queued at drive time and
// compared one cycle after the vsync rising edge.
module tb_player_input;
    import overcooked_pkg::*;

`ifdef PLAYER_INPUT_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    typedef struct packed {
        logic       mv;
        logic [1:0] md;
        logic [1:0] fc;
        logic       cs;
        logic       ch;
        logic       cr;
        logic       cl;
    } out_t;

    typedef struct packed {
        logic u, d, l, r, chp, car;
    } in_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset, vsync, left, right, up, down, chop, carry;
    logic move_valid, chop_start, chopping, carry_req, carry_level;
    dir_t move_dir, facing;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    out_t        sb[$];
    vec_t        tbl[16];

    always #5 clock = ~clock;

    player_input #(
        .REPEAT_DELAY (12),
        .REPEAT_RATE  (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vsync       (vsync),
        .left        (left),
        .right       (right),
        .up          (up),
        .down        (down),
        .chop        (chop),
        .carry       (carry),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .facing      (facing),
        .chop_start  (chop_start),
        .chopping    (chopping),
        .carry_req   (carry_req),
        .carry_level (carry_level)
    );

    function automatic out_t mk(input logic mv, input logic [1:0] md, input logic [1:0] fc,
                                input logic cs, input logic ch, input logic cr, input logic cl);
        out_t o;
        o = '{mv: mv, md: md, fc: fc, cs: cs, ch: ch, cr: cr, cl: cl};
        return o;
    endfunction

    function automatic in_t mi(input logic u, input logic d, input logic l, input logic r,
                               input logic chp, input logic car);
        in_t i;
        i = '{u: u, d: d, l: l, r: r, chp: chp, car: car};
        return i;
    endfunction

    function automatic out_t actual();
        return mk(move_valid, move_dir, facing, chop_start, chopping, carry_req, carry_level);
    endfunction

    task automatic check(input string name, input int idx, input out_t got, input out_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s #%0d: got mv/dir/face/cs/ch/cr/cl=%b/%0d/%0d/%b/%b/%b/%b want %b/%0d/%0d/%b/%b/%b/%b",
                     name, idx, got.mv, got.md, got.fc, got.cs, got.ch, got.cr, got.cl,
                     want.mv, want.md, want.fc, want.cs, want.ch, want.cr, want.cl);
        end
    endtask

    task automatic drive(input in_t i);
        up = i.u; down = i.d; left = i.l; right = i.r; chop = i.chp; carry = i.car;
    endtask

    // One frame: raise vsync with new inputs, check the registered result,
    // then check the pulses drop after one cycle.
    task automatic frame(input string name, input int idx, input in_t i, input out_t e);
        out_t want;
        @(negedge clock);
        drive(i);
        vsync = 1'b1;
        sb.push_back(e);
        @(posedge clock); #1;
        if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s #%0d: scoreboard empty", name, idx);
        end else begin
            want = sb.pop_front();
            check(name, idx, actual(), want);
            want.mv = 1'b0; want.cs = 1'b0; want.cr = 1'b0;
            @(posedge clock); #1;
            check({name, "_pulse_clear"}, idx, actual(), want);
        end
        @(negedge clock);
        vsync = 1'b0;
        repeat (2) @(posedge clock);
    endtask

    initial begin
        bit mv;
        logic [1:0] dd;
        reset = 1'b1; vsync = 1'b0;
        drive(mi(0, 0, 0, 0, 0, 0));

        tbl[0]  = '{mi(1,0,0,0,0,0), mk(1, DIR_UP,    DIR_UP,    0,0,0,0)};
        tbl[1]  = '{mi(0,0,0,0,0,0), mk(0, DIR_UP,    DIR_UP,    0,0,0,0)};
        tbl[2]  = '{mi(0,0,1,0,1,1), mk(1, DIR_LEFT,  DIR_LEFT,  1,1,1,1)};
        tbl[3]  = '{mi(0,0,1,0,1,1), mk(0, DIR_LEFT,  DIR_LEFT,  0,1,0,1)};
        tbl[4]  = '{mi(0,0,0,0,0,1), mk(0, DIR_LEFT,  DIR_LEFT,  0,0,0,1)};
        tbl[5]  = '{mi(0,1,0,1,0,0), mk(1, DIR_DOWN,  DIR_DOWN,  0,0,1,0)};
        tbl[6]  = '{mi(0,0,0,1,0,0), mk(1, DIR_RIGHT, DIR_RIGHT, 0,0,0,0)};
        tbl[7]  = '{mi(1,1,1,1,0,0), mk(1, DIR_UP,    DIR_UP,    0,0,0,0)};
        tbl[8]  = '{mi(0,0,1,1,0,0), mk(1, DIR_LEFT,  DIR_LEFT,  0,0,0,0)};
        tbl[9]  = '{mi(0,0,1,1,0,0), mk(0, DIR_LEFT,  DIR_LEFT,  0,0,0,0)};
        tbl[10] = '{mi(0,0,0,0,0,0), mk(0, DIR_LEFT,  DIR_LEFT,  0,0,0,0)};
        tbl[11] = '{mi(0,0,0,0,1,0), mk(0, DIR_LEFT,  DIR_LEFT,  1,1,0,0)};
        tbl[12] = '{mi(0,0,0,0,1,0), mk(0, DIR_LEFT,  DIR_LEFT,  0,1,0,0)};
        tbl[13] = '{mi(0,0,0,0,0,0), mk(0, DIR_LEFT,  DIR_LEFT,  0,0,0,0)};
        tbl[14] = '{mi(0,1,0,0,0,0), mk(1, DIR_DOWN,  DIR_DOWN,  0,0,0,0)};
        tbl[15] = '{mi(0,0,0,0,0,0), mk(0, DIR_DOWN,  DIR_DOWN,  0,0,0,0)};

        repeat (3) @(posedge clock); #1;
        check("reset_state", 0, actual(), mk(0, DIR_DOWN, DIR_DOWN, 0,0,0,0));
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(posedge clock);

        for (int k = 0; k < 16; k++)
            frame("table", k, tbl[k].in, tbl[k].exp);

        // Hold right for 30 frames.
        for (int f = 0; f < 30; f++) begin
            mv = (f == 0) || (REP && f >= 12 && ((f - 12) % 4) == 0);
            frame("hold_right", f, mi(0,0,0,1,0,0), mk(mv, DIR_RIGHT, DIR_RIGHT, 0,0,0,0));
        end
        frame("release_right", 0, mi(0,0,0,0,0,0), mk(0, DIR_RIGHT, DIR_RIGHT, 0,0,0,0));

        // Hold left, add up at frame 5.
        for (int f = 0; f < 19; f++) begin
            mv = (f == 0) || (f == 5) || (REP && f == 17);
            dd = (f < 5) ? DIR_LEFT : DIR_UP;
            frame("left_then_up", f, mi(f >= 5, 0, 1, 0, 0, 0), mk(mv, dd, dd, 0,0,0,0));
        end
        frame("release_up", 0, mi(0,0,0,0,0,0), mk(0, DIR_UP, DIR_UP, 0,0,0,0));

        // Hold down into the repeat phase, then reset mid-hold.
        for (int f = 0; f < 14; f++) begin
            mv = (f == 0) || (REP && f == 12);
            frame("hold_down", f, mi(0,1,0,0,0,1), mk(mv, DIR_DOWN, DIR_DOWN, 0,0,(f == 0),1));
        end
        @(negedge clock);
        reset = 1'b1; vsync = 1'b1; chop = 1'b1; carry = 1'b0;
        @(posedge clock); #1;
        check("reset_mid_hold", 0, actual(), mk(0, DIR_DOWN, DIR_DOWN, 0,0,0,0));
        @(posedge clock); #1;
        check("reset_mid_hold", 1, actual(), mk(0, DIR_DOWN, DIR_DOWN, 0,0,0,0));
        @(negedge clock);
        reset = 1'b0; vsync = 1'b0;
        repeat (2) @(posedge clock);
        frame("after_reset", 0, mi(0,1,0,0,1,0), mk(1, DIR_DOWN, DIR_DOWN, 0,1,0,0));
        frame("after_reset", 1, mi(0,1,0,0,1,0), mk(0, DIR_DOWN, DIR_DOWN, 0,1,0,0));
        frame("after_reset", 2, mi(0,0,0,0,0,0), mk(0, DIR_DOWN, DIR_DOWN, 0,0,0,0));

        if (sb.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
